// File: rtl/bsg_fsb_rr_hub.sv
// bsg_fsb_rr_hub
//   N-node front-side-bus hub between the comm-link core interface (asm side)
//   and nodes_p client nodes.
//   - Inbound packets are steered to one node by their destination id field.
//   - In-band control packets (ctrl bit set) enable, disable or reset nodes.
//   - Outbound node traffic is round-robin arbitrated into a registered
//     asm output stage that moves one packet per cycle.
//
// Ports
//   clk_i, async_reset_n_i      clock, asynchronous active-low reset
//   asm_v_i/asm_data_i          inbound packet from the core
//   asm_yumi_o                  inbound packet consumed this cycle
//   asm_v_o/asm_data_o          registered outbound packet to the core
//   asm_ready_i                 core can accept the outbound packet
//   node_v_o/node_data_o        per-node inbound valid, shared inbound data
//   node_ready_i                per-node inbound ready
//   node_v_i/node_data_i        per-node outbound valid and data
//   node_yumi_o                 per-node outbound packet consumed
//   node_en_r_o                 registered node enables
//   node_reset_r_o              registered node resets (active high)
//   drop_cnt_r_o                saturating dropped-packet count
//
// Optional feature
//   `define BSG_FSB_RR_HUB_DROP_CNT_EN to add the drop_cnt_r_o port and its
//   8-bit saturating counter. Without it, dropped packets are silent.

module bsg_fsb_rr_hub #(
  parameter int                 width_p                = 80,
  parameter int                 nodes_p                = 4,
  parameter int                 id_width_p             = 4,
  parameter logic [nodes_p-1:0] enabled_at_start_vec_p = '0,
  parameter int                 reset_cycles_p         = 8
) (
  input  logic                 clk_i,
  input  logic                 async_reset_n_i,
  input  logic                 asm_v_i,
  input  logic [width_p-1:0]   asm_data_i,
  output logic                 asm_yumi_o,
  output logic                 asm_v_o,
  output logic [width_p-1:0]   asm_data_o,
  input  logic                 asm_ready_i,
  output logic [nodes_p-1:0]   node_v_o,
  output logic [width_p-1:0]   node_data_o,
  input  logic [nodes_p-1:0]   node_ready_i,
  input  logic [nodes_p-1:0]   node_v_i,
  input  logic [width_p-1:0]   node_data_i [nodes_p-1:0],
  output logic [nodes_p-1:0]   node_yumi_o,
  output logic [nodes_p-1:0]   node_en_r_o,
`ifdef BSG_FSB_RR_HUB_DROP_CNT_EN
  output logic [7:0]           drop_cnt_r_o,
`endif
  output logic [nodes_p-1:0]   node_reset_r_o
);

  localparam int ptr_w = (nodes_p > 1) ? $clog2(nodes_p) : 1;
  localparam int cnt_w = $clog2(reset_cycles_p + 1);
  localparam logic [cnt_w-1:0] cnt_load = cnt_w'(reset_cycles_p);

  // Packet field decode
  logic [id_width_p-1:0] dest;
  logic                  ctrl;
  logic [1:0]            opcode;

  assign dest   = asm_data_i[width_p-1 -: id_width_p];
  assign ctrl   = asm_data_i[width_p-id_width_p-1];
  assign opcode = asm_data_i[1:0];

  // One-hot destination; all zero when the id names no existing node,
  // which keeps every per-node lookup below in range.
  logic [nodes_p-1:0] dest_oh;

  always_comb begin
    dest_oh = '0;
    for (int i = 0; i < nodes_p; i++) begin
      dest_oh[i] = (dest == id_width_p'(i));
    end
  end

  logic [nodes_p-1:0] live;
  logic               dest_in_range;
  logic               dest_live;
  logic               dest_ready;

  assign live          = node_en_r_o & ~node_reset_r_o;
  assign dest_in_range = |dest_oh;
  assign dest_live     = |(dest_oh & live);
  assign dest_ready    = |(dest_oh & node_ready_i);

  // Inbound classification: control, deliverable data, or drop
  logic ctrl_v;
  logic data_v;
  logic drop;

  assign ctrl_v = asm_v_i & ctrl & dest_in_range;
  assign data_v = asm_v_i & ~ctrl & dest_live;
  assign drop   = asm_v_i & ~ctrl_v & ~data_v;

  assign asm_yumi_o  = ctrl_v | drop | (data_v & dest_ready);
  assign node_v_o    = data_v ? dest_oh : '0;
  assign node_data_o = asm_data_i;

  logic [nodes_p-1:0] op_en;
  logic [nodes_p-1:0] op_dis;
  logic [nodes_p-1:0] op_rst;

  assign op_en  = (ctrl_v && opcode == 2'b01) ? dest_oh : '0;
  assign op_dis = (ctrl_v && opcode == 2'b10) ? dest_oh : '0;
  assign op_rst = (ctrl_v && opcode == 2'b11) ? dest_oh : '0;

  // Per-node reset counters; a reload always wins over the decrement so a
  // repeated reset command restarts the full count.
  logic [cnt_w-1:0] rst_cnt   [nodes_p];
  logic [cnt_w-1:0] rst_cnt_n [nodes_p];

  always_comb begin
    for (int i = 0; i < nodes_p; i++) begin
      rst_cnt_n[i] = '0;
      if (op_rst[i]) begin
        rst_cnt_n[i] = cnt_load;
      end else if (rst_cnt[i] != '0) begin
        rst_cnt_n[i] = rst_cnt[i] - cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      node_en_r_o    <= enabled_at_start_vec_p;
      node_reset_r_o <= '1;
      for (int i = 0; i < nodes_p; i++) begin
        rst_cnt[i] <= cnt_load;
      end
    end else begin
      node_en_r_o <= (node_en_r_o | op_en) & ~op_dis;
      for (int i = 0; i < nodes_p; i++) begin
        rst_cnt[i]        <= rst_cnt_n[i];
        node_reset_r_o[i] <= (rst_cnt_n[i] != '0);
      end
    end
  end

  // Outbound round-robin: first live requester at or after rr_ptr
  logic [nodes_p-1:0] req;
  logic               load;
  logic [ptr_w-1:0]   rr_ptr;
  logic [ptr_w-1:0]   grant_idx;
  logic               grant_v;
  logic [ptr_w-1:0]   ptr_next;

  assign req  = node_v_i & live;
  assign load = ~asm_v_o | asm_ready_i;

  always_comb begin
    int idx;
    grant_v   = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < nodes_p; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= nodes_p) begin
        idx = idx - nodes_p;
      end
      if (!grant_v && req[ptr_w'(idx)]) begin
        grant_v   = 1'b1;
        grant_idx = ptr_w'(idx);
      end
    end
  end

  assign ptr_next    = (grant_idx == ptr_w'(nodes_p - 1)) ? '0 : grant_idx + ptr_w'(1);
  assign node_yumi_o = (load && grant_v) ? (nodes_p'(1) << grant_idx) : '0;

  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      asm_v_o    <= 1'b0;
      asm_data_o <= '0;
      rr_ptr     <= '0;
    end else if (load) begin
      asm_v_o <= grant_v;
      if (grant_v) begin
        asm_data_o <= node_data_i[grant_idx];
        rr_ptr     <= ptr_next;
      end
    end
  end

`ifdef BSG_FSB_RR_HUB_DROP_CNT_EN
  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      drop_cnt_r_o <= '0;
    end else if (drop && drop_cnt_r_o != 8'hFF) begin
      drop_cnt_r_o <= drop_cnt_r_o + 8'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule
